// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request at a time, response valid LATENCY edges after accept.
// Backpressure: req_ready only in IDLE; the response is held until resp_ready.
module dmem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_LEN   = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_LEN-1:0]   req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic [WIDTH/8-1:0]    req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_err
);
    localparam int NBYTES = WIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];

    assign req_ready  = reset && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = err_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_d        = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[DEPTH_LOG2+1:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    // High address bits only feed the range check, never the index.
                    err_d   = (req_addr[1:0] != 2'b00) ||
                              (req_addr[ADDR_LEN-1:DEPTH_LOG2+2] != '0);
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_err_d   = err_q;
                    resp_rdata_d = '0;
                    if (!err_q) begin
                        if (we_q) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (wstrb_q[i]) begin
                                    mem_d[idx_q][8*i +: 8] = wdata_q[8*i +: 8];
                                end
                            end
                        end else begin
                            resp_rdata_d = mem_q[idx_q];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            err_q        <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
